// File: rtl/random_galois_23bit_checker.sv
// -----------------------------------------------------------------------------
// random_galois_23bit_checker
//
// Purpose:
//   Tracks a stream of 23-bit words produced by the Galois random source and
//   reports whether the stream is synchronized. A prediction register (PRED)
//   holds the word expected next.
//   - SEARCH: waits for a nonzero sample to seed the prediction.
//   - VERIFY: requires LOCK_THRESHOLD consecutive matching samples. Any
//     mismatch reseeds from the observed word.
//   - LOCKED: free-runs ("flywheels") the prediction from itself. Each
//     mismatch is reported and counted. UNLOCK_THRESHOLD consecutive
//     mismatches drop back to VERIFY, or to SEARCH if the word was zero.
//
// Ports:
//   clk            : rising-edge clock
//   rst            : synchronous, active-high reset
//   i_valid        : i_random_data holds a sample this cycle
//   i_random_data  : observed random word, bits [23:1]
//   i_clear        : zeroes o_error_count on the next edge (wins over a count)
//   o_locked       : registered; 1 while the checker is in LOCKED
//   o_error        : registered one-cycle pulse per mismatch while LOCKED
//   o_error_count  : registered saturating count of LOCKED mismatches
// -----------------------------------------------------------------------------
module random_galois_23bit_checker #(
  parameter int LOCK_THRESHOLD   = 8,
  parameter int UNLOCK_THRESHOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [23:1] i_random_data,
  input  logic        i_clear,
  output logic        o_locked,
  output logic        o_error,
  output logic [15:0] o_error_count
);

  localparam int DATA_W  = 23;
  localparam int CNT_W   = 16;
  localparam int MATCH_W = (LOCK_THRESHOLD   < 2) ? 1 : $clog2(LOCK_THRESHOLD + 1);
  localparam int MISS_W  = (UNLOCK_THRESHOLD < 2) ? 1 : $clog2(UNLOCK_THRESHOLD + 1);

  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_THRESHOLD - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(UNLOCK_THRESHOLD - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Next-state function of the Galois source. Bit 1 is the output tap; it
  // wraps to bit 23 and is also folded into bit 4.
  function automatic logic [DATA_W:1] galois_next(input logic [DATA_W:1] x);
    return {x[1], x[23:6], x[1] ^ x[6], x[4:2]};
  endfunction

  // Saturating increment: the error count sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end
    return c + CNT_W'(1);
  endfunction

  // State registers
  state_t              r_state;
  logic [DATA_W:1]     r_pred;
  logic [MATCH_W-1:0]  r_match_cnt;
  logic [MISS_W-1:0]   r_miss_cnt;
  logic                r_locked;
  logic                r_error;
  logic [CNT_W-1:0]    r_error_count;

  // Next-state values
  state_t              w_state_nxt;
  logic [DATA_W:1]     w_pred_nxt;
  logic [MATCH_W-1:0]  w_match_nxt;
  logic [MISS_W-1:0]   w_miss_nxt;
  logic                w_error_nxt;
  logic [CNT_W-1:0]    w_count_nxt;

  // Sample classification
  logic                w_match;
  logic                w_zero;
  logic [DATA_W:1]     w_seed;
  logic [DATA_W:1]     w_fly;

  assign w_match = (i_random_data == r_pred);
  assign w_zero  = (i_random_data == '0);
  assign w_seed  = galois_next(i_random_data);
  assign w_fly   = galois_next(r_pred);

  always_comb begin
    w_state_nxt = r_state;
    w_pred_nxt  = r_pred;
    w_match_nxt = r_match_cnt;
    w_miss_nxt  = r_miss_cnt;
    w_error_nxt = 1'b0;
    w_count_nxt = r_error_count;

    if (i_valid) begin
      case (r_state)
        ST_SEARCH: begin
          // Zero is the lockup point of the source and must never seed.
          if (!w_zero) begin
            w_pred_nxt  = w_seed;
            w_match_nxt = '0;
            w_state_nxt = ST_VERIFY;
          end
        end

        ST_VERIFY: begin
          if (w_match) begin
            w_pred_nxt = w_seed;
            if (r_match_cnt == MATCH_LAST) begin
              w_state_nxt = ST_LOCKED;
              w_match_nxt = '0;
              w_miss_nxt  = '0;
            end else begin
              w_match_nxt = r_match_cnt + MATCH_W'(1);
            end
          end else if (w_zero) begin
            w_state_nxt = ST_SEARCH;
            w_match_nxt = '0;
          end else begin
            w_pred_nxt  = w_seed;
            w_match_nxt = '0;
          end
        end

        ST_LOCKED: begin
          // Once locked the prediction runs from itself, so a corrupted
          // sample does not disturb the expected sequence.
          w_pred_nxt = w_fly;
          if (w_match) begin
            w_miss_nxt = '0;
          end else begin
            w_error_nxt = 1'b1;
            w_count_nxt = sat_inc(r_error_count);
            if (r_miss_cnt == MISS_LAST) begin
              w_miss_nxt  = '0;
              w_match_nxt = '0;
              if (w_zero) begin
                w_state_nxt = ST_SEARCH;
              end else begin
                w_state_nxt = ST_VERIFY;
                w_pred_nxt  = w_seed;
              end
            end else begin
              w_miss_nxt = r_miss_cnt + MISS_W'(1);
            end
          end
        end

        default: begin
          w_state_nxt = ST_SEARCH;
          w_pred_nxt  = '0;
          w_match_nxt = '0;
          w_miss_nxt  = '0;
        end
      endcase
    end

    // Clear takes priority over an error counted in the same cycle.
    if (i_clear) begin
      w_count_nxt = '0;
    end
  end

  // Register stage: every output comes straight from a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_SEARCH;
      r_pred        <= '0;
      r_match_cnt   <= '0;
      r_miss_cnt    <= '0;
      r_locked      <= 1'b0;
      r_error       <= 1'b0;
      r_error_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pred        <= w_pred_nxt;
      r_match_cnt   <= w_match_nxt;
      r_miss_cnt    <= w_miss_nxt;
      r_locked      <= (w_state_nxt == ST_LOCKED);
      r_error       <= w_error_nxt;
      r_error_count <= w_count_nxt;
    end
  end

  assign o_locked      = r_locked;
  assign o_error       = r_error;
  assign o_error_count = r_error_count;

endmodule

// File: tb/tb_random_galois_23bit_checker.sv
module tb_random_galois_23bit_checker;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (default thresholds)
  logic        rst, i_valid, i_clear;
  logic [23:1] i_random_data;
  logic        o_locked, o_error;
  logic [15:0] o_error_count;

  random_galois_23bit_checker dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_random_data(i_random_data),
    .i_clear(i_clear), .o_locked(o_locked), .o_error(o_error),
    .o_error_count(o_error_count)
  );

  // Saturation DUT: unlock threshold large enough to stay locked through 65536 errors
  logic        s_rst, s_valid, s_clear;
  logic [23:1] s_data;
  logic        s_locked, s_error;
  logic [15:0] s_count;

  random_galois_23bit_checker #(.LOCK_THRESHOLD(8), .UNLOCK_THRESHOLD(70000)) dut_sat (
    .clk(clk), .rst(s_rst), .i_valid(s_valid), .i_random_data(s_data),
    .i_clear(s_clear), .o_locked(s_locked), .o_error(s_error),
    .o_error_count(s_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        locked;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  // Source next-state, written bit by bit from the definition
  function automatic logic [23:1] fgal(input logic [23:1] x);
    logic [23:1] y;
    y[23] = x[1];
    for (int k = 5; k <= 22; k++) y[k] = x[k+1];
    y[4] = x[1] ^ x[6];
    for (int k = 1; k <= 3; k++) y[k] = x[k+1];
    return y;
  endfunction

  // Drive one cycle; expectation for the outputs after this edge is queued
  task automatic step(input logic v, input logic [23:1] d, input logic c, input logic r,
                      input logic el, input logic ee, input logic [15:0] ec, input string nm);
    exp_t e;
    rst = r; i_valid = v; i_random_data = d; i_clear = c;
    e.locked = el; e.err = ee; e.cnt = ec;
    @(posedge clk);
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1;
  endtask

  // Monitor: compares registered outputs mid-cycle
  exp_t  mon_e;
  string mon_n;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      n_cmp++;
      if (o_locked !== mon_e.locked || o_error !== mon_e.err || o_error_count !== mon_e.cnt) begin
        n_bad++;
        $display("FAIL %s: got locked=%0b error=%0b count=%0d, want locked=%0b error=%0b count=%0d",
                 mon_n, o_locked, o_error, o_error_count, mon_e.locked, mon_e.err, mon_e.cnt);
      end
    end
  end

  task automatic chk_sat(input string nm, input logic l, input logic e, input logic [15:0] c);
    n_cmp++;
    if (s_locked !== l || s_error !== e || s_count !== c) begin
      n_bad++;
      $display("FAIL %s: got locked=%0b error=%0b count=%0d, want locked=%0b error=%0b count=%0d",
               nm, s_locked, s_error, s_count, l, e, c);
    end
  endtask

  logic [23:1] seq, w, sp;

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_random_data = '0; i_clear = 1'b0;
    s_rst = 1'b1; s_valid = 1'b0; s_data = '0; s_clear = 1'b0;
    @(posedge clk); #1;

    // Reset with valid high
    step(1, 23'd65, 0, 1, 0, 0, 0, "reset");
    step(1, 23'd65, 1, 1, 0, 0, 0, "reset_clear");

    // Seed check of the definition example
    n_cmp++;
    if (fgal(23'd65) !== 23'd4194344) begin
      n_bad++;
      $display("FAIL f65: got %0d want 4194344", fgal(23'd65));
    end

    // Lock: 9 consecutive valid samples
    seq = 23'd65;
    for (int i = 1; i <= 9; i++) begin
      step(1, seq, 0, 0, (i == 9), 0, 0, "lock");
      seq = fgal(seq);
    end

    // Single error then resume
    step(1, seq ^ 23'd1, 0, 0, 1, 1, 1, "single_err");
    seq = fgal(seq);
    for (int i = 0; i < 3; i++) begin
      step(1, seq, 0, 0, 1, 0, 1, "resume");
      seq = fgal(seq);
    end

    // Valid gaps of 1..5 cycles with garbage on the data bus
    for (int g = 1; g <= 5; g++) begin
      for (int k = 0; k < g; k++) step(0, 23'h7FFFFF, 0, 0, 1, 0, 1, "gap_idle");
      step(1, seq, 0, 0, 1, 0, 1, "gap_sample");
      seq = fgal(seq);
    end

    // Plain clear
    step(1, seq, 1, 0, 1, 0, 0, "clear");
    seq = fgal(seq);

    // Unlock: 4 consecutive wrong nonzero words
    for (int i = 1; i <= 4; i++) begin
      w = seq ^ 23'h15A5A5;
      step(1, w, 0, 0, (i < 4), 1, 16'(i), "unlock");
      seq = (i == 4) ? fgal(w) : fgal(seq);
    end

    // Re-lock from the last wrong word's seed
    for (int i = 1; i <= 8; i++) begin
      step(1, seq, 0, 0, (i == 8), 0, 4, "relock");
      seq = fgal(seq);
    end

    // Clear concurrent with an error
    step(1, seq ^ 23'd1, 1, 0, 1, 1, 0, "clear_vs_err");
    seq = fgal(seq);
    step(1, seq ^ 23'd1, 0, 0, 1, 1, 1, "err_pre_rst");
    seq = fgal(seq);

    // Reset mid-lock
    step(1, seq, 1, 1, 0, 0, 0, "rst_midlock");

    // All-zero stream
    for (int i = 0; i < 50; i++) step(1, 23'd0, 0, 0, 0, 0, 0, "zero_stream");

    // VERIFY mismatch reseeds without errors
    step(1, 23'd65, 0, 0, 0, 0, 0, "seed");
    step(1, fgal(23'd65), 0, 0, 0, 0, 0, "verify_match");
    step(1, 23'h123456, 0, 0, 0, 0, 0, "verify_reseed");
    seq = fgal(23'h123456);
    for (int i = 1; i <= 8; i++) begin
      step(1, seq, 0, 0, (i == 8), 0, 0, "lock_after_reseed");
      seq = fgal(seq);
    end
    for (int i = 0; i < 3; i++) step(0, 23'd0, 0, 0, 1, 0, 0, "idle_hold");

    i_valid = 1'b0; rst = 1'b0; i_clear = 1'b0;

    // Saturation on the second instance
    @(posedge clk); #1;
    s_rst = 1'b0;
    sp = 23'd65;
    for (int i = 0; i < 9; i++) begin
      s_valid = 1'b1; s_data = sp; sp = fgal(sp);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 65535; i++) begin
      s_data = sp ^ 23'd1; sp = fgal(sp);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk_sat("sat_preload", 1, 1, 16'hFFFF);
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = sp ^ 23'd1; sp = fgal(sp);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk_sat("sat_hold", 1, 1, 16'hFFFF);
    @(posedge clk); #1;
    s_valid = 1'b1; s_clear = 1'b1; s_data = sp ^ 23'd1; sp = fgal(sp);
    @(posedge clk); #1;
    s_valid = 1'b0; s_clear = 1'b0;
    @(negedge clk);
    chk_sat("sat_clear_vs_err", 1, 1, 16'd0);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/random_galois_23bit_checker.md
RANDOM_GALOIS_23BIT_CHECKER -- requirements
Module: random_galois_23bit_checker

Definitions
- F(x): 23-bit next-state function of the team's Galois random source, bits [23:1].
  - F(x)[23] = x[1]
  - F(x)[22:5] = x[23:6]
  - F(x)[4] = x[1] ^ x[6]
  - F(x)[3:1] = x[4:2]
- Example: F(65) = 4194344 (0x400028).
- A sample "matches" when it equals the current prediction register PRED.

Interface
REQ-001 Parameter LOCK_THRESHOLD, default 8: consecutive matches in VERIFY needed to declare lock.
REQ-002 Parameter UNLOCK_THRESHOLD, default 4: consecutive mismatches in LOCKED needed to drop lock.
REQ-003 Port `clk`, input, 1 bit: single clock; all logic on the rising edge.
REQ-004 Port `rst`, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port `i_valid`, input, 1 bit: i_random_data carries a sample this cycle.
REQ-006 Port `i_random_data`, input, 23 bits [23:1]: observed random word.
REQ-007 Port `i_clear`, input, 1 bit: clears o_error_count.
REQ-008 Port `o_locked`, output, 1 bit: checker is synchronized to the stream.
REQ-009 Port `o_error`, output, 1 bit: one-cycle pulse for each mismatch while LOCKED.
REQ-010 Port `o_error_count`, output, 16 bits: saturating count of LOCKED mismatches.

Function
REQ-011 State machine SHALL have states SEARCH, VERIFY and LOCKED; it SHALL also hold PRED[23:1], MATCH_CNT and MISS_CNT.
REQ-012 When i_valid=0, state, PRED and counters SHALL hold, and o_error SHALL be 0 the following cycle.
REQ-013 SEARCH, valid nonzero sample S: PRED<=F(S), MATCH_CNT<=0, go to VERIFY.
REQ-014 SEARCH, valid zero sample: stay in SEARCH (F(0)=0 is a lockup point and SHALL never seed).
REQ-015 VERIFY, valid match: PRED<=F(S), MATCH_CNT+1.
REQ-016 VERIFY, reaching LOCK_THRESHOLD matches: go to LOCKED and MISS_CNT<=0; o_locked SHALL be 1 from the next cycle.
REQ-017 VERIFY, valid mismatch with S nonzero: PRED<=F(S) (reseed), MATCH_CNT<=0.
REQ-018 VERIFY, valid mismatch with S zero: go to SEARCH.
REQ-019 VERIFY mismatches SHALL NOT pulse o_error or count.
REQ-020 LOCKED, valid match: PRED<=F(PRED), MISS_CNT<=0.
REQ-021 LOCKED, valid mismatch: PRED<=F(PRED) (flywheel, no reseed), o_error=1 next cycle, o_error_count+1, MISS_CNT+1.
REQ-022 LOCKED, mismatch making MISS_CNT reach UNLOCK_THRESHOLD: o_error and count still apply; then go to VERIFY with PRED<=F(S) and MATCH_CNT<=0 (SEARCH if S=0); o_locked=0 next cycle.
REQ-023 o_error_count SHALL saturate at 65535 and never wrap.
REQ-024 i_clear SHALL set o_error_count to 0 next cycle; if asserted in the same cycle as a counted error, clear wins (result 0); o_error still pulses.
REQ-025 All outputs SHALL be registered; latency from a sample to its o_error/o_locked effect is exactly 1 cycle.

Reset
REQ-026 rst=1 SHALL force SEARCH, PRED=0, MATCH_CNT=0, MISS_CNT=0, o_locked=0, o_error=0, o_error_count=0 on the next edge, overriding i_valid and i_clear, including mid-lock.

Verification
REQ-027 Reset: assert rst for 2 cycles with i_valid=1 -> all outputs 0, state SEARCH.
REQ-028 Lock: feed 65, F(65)=4194344, ... for 9 consecutive valid cycles -> o_locked=1 the cycle after the 9th sample; o_error_count=0.
REQ-029 Single error: while locked, flip bit 1 of one sample, then resume the correct sequence -> one o_error pulse, count=1, o_locked stays 1, next sample matches.
REQ-030 Unlock: while locked, send 4 consecutive wrong nonzero words -> count=4, o_locked=0 after the 4th; re-lock after 8 further matching samples.
REQ-031 Zero and gaps: all-zero stream for 50 cycles -> never leaves SEARCH; a locked stream with i_valid gaps of 1-5 cycles -> no errors, lock held.
REQ-032 Clear/saturation: preload 65535 errors, inject one more -> stays 65535; i_clear concurrent with an error -> count 0 and o_error=1; rst mid-lock -> all outputs 0.
